// File: rtl/fp_regfile.sv
// FP register file with fcsr ownership, dynamic rounding mode and a
// per-register pending scoreboard for multi-cycle FP operations.
//
// Ports:
//   clk, resetn          clock, async active-low reset
//   rd_addr / rd_data    NRD combinational read ports (write bypass)
//   hazard               per read port: register still pending
//   wr_en/addr/data      writeback port; wr_flags accrue into fflags
//   iss_en / iss_addr    issue strobe, marks destination pending
//   csr_op/sel/wdata     fflags/frm/fcsr access; csr_rdata = old value
//   instr_rm             instruction rounding-mode field
//   rm_out / rm_illegal  resolved rounding mode and reserved flag
module fp_regfile #(
    parameter  int FLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 3,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*FLEN-1:0] rd_data,
    output logic [NRD-1:0]    hazard,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [FLEN-1:0]   wr_data,
    input  logic [4:0]        wr_flags,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [1:0]        csr_op,
    input  logic [1:0]        csr_sel,
    input  logic [7:0]        csr_wdata,
    output logic [7:0]        csr_rdata,
    input  logic [2:0]        instr_rm,
    output logic [2:0]        rm_out,
    output logic              rm_illegal
);

    localparam logic [AW:0] NR = (AW+1)'(NREGS);

    logic [FLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [7:0]       fcsr;
    logic [7:0]       fcsr_next;
    logic [7:0]       csr_cur;
    logic [7:0]       csr_opd;
    logic [7:0]       csr_new;
    logic             wr_ok;
    logic             iss_ok;

    // Out-of-range indices exist only when NREGS is not a power of two.
    assign wr_ok  = wr_en && ({1'b0, wr_addr} < NR);
    assign iss_ok = iss_en && ({1'b0, iss_addr} < NR);

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          v;
        logic          byp;
        assign a   = rd_addr[i*AW +: AW];
        assign v   = ({1'b0, a} < NR);
        assign byp = wr_en && (wr_addr == a) && v;
        assign rd_data[i*FLEN +: FLEN] =
            !v  ? '0 :
            byp ? wr_data : regs[a];
        // A same-cycle writeback supplies the value, so no stall.
        assign hazard[i] = v && pending[a] && !byp;
    end

    always_comb begin
        csr_cur = '0;
        csr_opd = '0;
        unique case (csr_sel)
            2'd0: begin
                csr_cur = {3'b0, fcsr[4:0]};
                csr_opd = {3'b0, csr_wdata[4:0]};
            end
            2'd1: begin
                csr_cur = {5'b0, fcsr[7:5]};
                csr_opd = {5'b0, csr_wdata[2:0]};
            end
            2'd2: begin
                csr_cur = fcsr;
                csr_opd = csr_wdata;
            end
            default: ;
        endcase

        unique case (csr_op)
            2'b01:   csr_new = csr_opd;
            2'b10:   csr_new = csr_cur | csr_opd;
            2'b11:   csr_new = csr_cur & ~csr_opd;
            default: csr_new = csr_cur;
        endcase

        fcsr_next = fcsr;
        if (csr_op != 2'b00) begin
            unique case (csr_sel)
                2'd0:    fcsr_next[4:0] = csr_new[4:0];
                2'd1:    fcsr_next[7:5] = csr_new[2:0];
                2'd2:    fcsr_next      = csr_new;
                default: ;
            endcase
        end
        // Accrue after the CSR op so a same-cycle clear keeps new flags.
        if (wr_en)
            fcsr_next[4:0] = fcsr_next[4:0] | wr_flags;
    end

    assign csr_rdata  = csr_cur;
    assign rm_out     = (instr_rm == 3'b111) ? fcsr[7:5] : instr_rm;
    assign rm_illegal = (rm_out >= 3'd5);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            pending <= '0;
            fcsr    <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr]    <= wr_data;
                pending[wr_addr] <= 1'b0;
            end
            // Issue after writeback: the new producer owns the register.
            if (iss_ok)
                pending[iss_addr] <= 1'b1;
            fcsr <= fcsr_next;
        end
    end

endmodule
